// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_FIN,
    ST_ERR
  } state_t;

  localparam int LEN_BYTES = 2;

  function automatic int bytes_per_word(input int dbits);
    return dbits / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int Abits = 9,
  parameter int Dbits = 32
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             we;
  logic [Abits-1:0] waddr;
  logic [Dbits-1:0] wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs an MSB-first byte stream into words; word_valid marks the byte
// that completes a word, with word already including that byte.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int Dbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             take,
  input  logic [7:0]       din,
  output logic [Dbits-1:0] word,
  output logic             word_valid
);

  localparam int BPW = bytes_per_word(Dbits);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST = IW'(BPW - 1);

  logic [Dbits-1:0] shift_q;
  logic [IW-1:0]    idx_q;

  assign word       = (shift_q << 8) | Dbits'(din);
  assign word_valid = take && (idx_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (take) begin
      shift_q <= word;
      idx_q   <= word_valid ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed program loader into instruction RAM; holds the CPU while loading.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for count high byte (consumed on entry, LEN_HI passed through)
// LEN_HI | never resident; the high byte is taken in IDLE
// LEN_LO | waiting for count low byte, range-checks N
// DATA   | packing data bytes, one memory write per completed word
// CSUM   | waiting for checksum byte (checksum build only)
// FIN    | done pulse, processor released
// ERR    | err pulse, processor stays held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int Abits = 9,
  parameter int Dbits = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam int CW = Abits + 1;
  localparam int LW = 8 * LEN_BYTES;
  localparam int MW = LW + 1;
  localparam logic [MW-1:0] MAX_WORDS = MW'(1) << Abits;

  state_t           state_q, state_d;
  logic [7:0]       len_hi_q;
  logic [CW-1:0]    left_q;
  logic [Abits-1:0] addr_q;
  logic             hold_q;
  logic             accept;
  logic             load_len;
  logic             set_hold;
  logic             len_bad;
  logic             last_word;
  logic [LW-1:0]    frame_len;
  logic             pk_take;
  logic             pk_clear;
  logic [Dbits-1:0] pk_word;
  logic             pk_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign bus.in_ready = (state_q != ST_FIN) && (state_q != ST_ERR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign frame_len    = {len_hi_q, bus.in_data};
  assign len_bad      = (frame_len == '0) || ({1'b0, frame_len} > MAX_WORDS);
  assign last_word    = (left_q == CW'(1));
  assign pk_take      = accept && (state_q == ST_DATA);
  assign pk_clear     = accept && ((state_q == ST_IDLE) || (state_q == ST_LEN_LO));

  assign done     = (state_q == ST_FIN);
  assign err      = (state_q == ST_ERR);
  assign cpu_hold = hold_q;

  byte_packer #(.Dbits(Dbits)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .take      (pk_take),
    .din       (bus.in_data),
    .word      (pk_word),
    .word_valid(pk_valid)
  );

  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    set_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_LEN_LO;
          set_hold = 1'b1;
        end
      end
      ST_LEN_HI: state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_bad) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_DATA;
            load_len = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (pk_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_FIN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (bus.in_data == csum_q) ? ST_FIN : ST_ERR;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_hi_q  <= '0;
      left_q    <= '0;
      addr_q    <= '0;
      hold_q    <= 1'b0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      bus.we  <= 1'b0;
      if (state_q == ST_IDLE && accept) len_hi_q <= bus.in_data;
      // Count is range-checked before load, so it always fits in CW bits.
      if (load_len) begin
        left_q <= CW'(frame_len);
        addr_q <= '0;
      end
      if (pk_valid) begin
        bus.we    <= 1'b1;
        bus.waddr <= addr_q;
        bus.wdata <= pk_word;
        addr_q    <= addr_q + 1'b1;
        left_q    <= left_q - 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (load_len) csum_q <= '0;
      else if (pk_take) csum_q <= csum_q ^ bus.in_data;
`endif
      if (state_d == ST_FIN) hold_q <= 1'b0;
      else if (set_hold) hold_q <= 1'b1;
    end
  end

endmodule
